// File: rtl/rv_trace_pkg.sv
// Shared types and limits for the commit trace buffer.
// Optional RV_TRACE_SEQ_EN adds a 16-bit sequence field to each record.
package rv_trace_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;
  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
`ifdef RV_TRACE_SEQ_EN
    logic [SEQ_W-1:0] seq;
`endif
  } commit_rec_t;

endpackage

// File: rtl/rv_trace_fifo.sv
// Circular FIFO of commit records, first-word fall-through.
// Ports: push/wdata in, pop in, rdata out, full/empty/level out.
module rv_trace_fifo
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  commit_rec_t wdata_i,
  input  logic        pop_i,
  output commit_rec_t rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  commit_rec_t mem_q [DEPTH];
  logic do_push;
  logic do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &
                   (wptr_q[AW] != rptr_q[AW]);

  // A push into a full FIFO is legal only when the head leaves this cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/rv_commit_trace_buf.sv
// Commit trace buffer: qualifies writeback commits, buffers, counts drops.
// Ports: commit_* in, trace_* valid/ready out, level/overflow/drop_cnt.
// Macro RV_TRACE_SEQ_EN adds the trace_seq output and sequence counter.
module rv_commit_trace_buf
  import rv_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter bit DROP_X0 = 1'b1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trace_en,
  input  logic                  commit_valid,
  input  logic [31:0]           commit_pc,
  input  logic [4:0]            commit_rd,
  input  logic [31:0]           commit_data,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_pc,
  output logic [4:0]            trace_rd,
  output logic [31:0]           trace_data,
`ifdef RV_TRACE_SEQ_EN
  output logic [SEQ_W-1:0]      trace_seq,
`endif
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic        push_req;
  logic        pop;
  logic        full;
  logic        empty;
  logic        drop;
  commit_rec_t wrec;
  commit_rec_t hrec;

  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  assign push_req = commit_valid & trace_en &
                    ~(DROP_X0 & (commit_rd == 5'd0));
  assign pop      = ~empty & trace_ready;
  // The core cannot stall, so a full buffer loses the record.
  assign drop     = push_req & full & ~pop;

`ifdef RV_TRACE_SEQ_EN
  logic [SEQ_W-1:0] seq_q, seq_d;

  // Counts every qualified commit, dropped or not, so gaps are visible.
  assign seq_d = push_req ? seq_q + 1'b1 : seq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign wrec.seq  = seq_q;
  assign trace_seq = hrec.seq;
`endif

  assign wrec.pc   = commit_pc;
  assign wrec.rd   = commit_rd;
  assign wrec.data = commit_data;

  rv_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push_req),
    .wdata_i (wrec),
    .pop_i   (pop),
    .rdata_o (hrec),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != DROP_CNT_MAX) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign trace_valid = ~empty;
  assign trace_pc    = hrec.pc;
  assign trace_rd    = hrec.rd;
  assign trace_data  = hrec.data;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_rv_commit_trace_buf.sv
// Bench for rv_commit_trace_buf: queue model plus directed checks.
// Also drives a DROP_X0=0 instance for the x0 filtering case.
module tb_rv_commit_trace_buf;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_en = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_data = '0;
  logic        trace_ready = 1'b0;

  logic        trace_valid, v1;
  logic [31:0] trace_pc, pc1;
  logic [4:0]  trace_rd, rd1;
  logic [31:0] trace_data, data1;
  logic [4:0]  level, level1;
  logic        overflow, ovf1;
  logic [15:0] drop_cnt, drop1;
`ifdef RV_TRACE_SEQ_EN
  logic [15:0] trace_seq, seq1;
`endif

  always #5 clk = ~clk;

  rv_commit_trace_buf #(.DEPTH(DEPTH), .DROP_X0(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .trace_en(trace_en),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_data(trace_data),
`ifdef RV_TRACE_SEQ_EN
    .trace_seq(trace_seq),
`endif
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  rv_commit_trace_buf #(.DEPTH(DEPTH), .DROP_X0(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .trace_en(trace_en),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .trace_valid(v1), .trace_ready(trace_ready),
    .trace_pc(pc1), .trace_rd(rd1), .trace_data(data1),
`ifdef RV_TRACE_SEQ_EN
    .trace_seq(seq1),
`endif
    .level(level1), .overflow(ovf1), .drop_cnt(drop1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [15:0] seq;
  } mrec_t;

  mrec_t       mq[$];
  int          mdrop = 0;
  bit          movf = 0;
  logic [15:0] mseq = '0;
  bit          m_pop, m_req;
  mrec_t       m_new;

  // Reference behaviour: a bounded queue; pop happens before the
  // push so a push into a full queue that is draining still fits.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mdrop = 0;
      movf = 0;
      mseq = '0;
    end else begin
      m_pop = (mq.size() != 0) && trace_ready;
      m_req = commit_valid && trace_en && (commit_rd != 5'd0);
      if (m_pop) void'(mq.pop_front());
      if (m_req) begin
        m_new.pc = commit_pc;
        m_new.rd = commit_rd;
        m_new.data = commit_data;
        m_new.seq = mseq;
        if (mq.size() < DEPTH) mq.push_back(m_new);
        else begin
          movf = 1;
          if (mdrop != 65535) mdrop++;
        end
        mseq = mseq + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {63'd0, trace_valid}, {63'd0, mq.size() != 0});
    chk("m_level", {59'd0, level}, 64'(mq.size()));
    chk("m_ovf", {63'd0, overflow}, {63'd0, movf});
    chk("m_drop", {48'd0, drop_cnt}, 64'(mdrop));
    if (mq.size() != 0) begin
      chk("m_pc", {32'd0, trace_pc}, {32'd0, mq[0].pc});
      chk("m_rd", {59'd0, trace_rd}, {59'd0, mq[0].rd});
      chk("m_data", {32'd0, trace_data}, {32'd0, mq[0].data});
`ifdef RV_TRACE_SEQ_EN
      chk("m_seq", {48'd0, trace_seq}, {48'd0, mq[0].seq});
`endif
    end
  end

  task automatic drive(bit v, logic [31:0] pc, logic [4:0] rd,
                       logic [31:0] d, bit rdy);
    commit_valid = v;
    commit_pc = pc;
    commit_rd = rd;
    commit_data = d;
    trace_ready = rdy;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  int drops_before;
  logic [31:0] exp_pc;

  initial begin
    trace_en = 1'b1;
    do_reset();
    chk("rst_valid", {63'd0, trace_valid}, 64'd0);
    chk("rst_level", {59'd0, level}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("rst_pc", {32'd0, trace_pc}, 64'd0);

    drive(1, 32'h100, 5'd4, 32'hFFFFFFFE, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("one_valid", {63'd0, trace_valid}, 64'd1);
    chk("one_pc", {32'd0, trace_pc}, 64'h100);
    chk("one_rd", {59'd0, trace_rd}, 64'd4);
    chk("one_data", {32'd0, trace_data}, 64'hFFFFFFFE);
    chk("one_level", {59'd0, level}, 64'd1);
    step();
    chk("one_hold_pc", {32'd0, trace_pc}, 64'h100);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    chk("one_pop_lvl", {59'd0, level}, 64'd0);
    chk("one_pop_vld", {63'd0, trace_valid}, 64'd0);

    drive(1, 32'h200, 5'd0, 32'h55, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("x0_level", {59'd0, level}, 64'd0);
    chk("x0_drop", {48'd0, drop_cnt}, 64'd0);
    chk("x0_keep_lvl", {59'd0, level1}, 64'd1);
    chk("x0_keep_pc", {32'd0, pc1}, 64'h200);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;

    trace_en = 1'b0;
    drive(1, 32'h300, 5'd3, 32'h1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    trace_en = 1'b1;
    chk("en_off_lvl", {59'd0, level}, 64'd0);

    for (int i = 0; i < 19; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 5'((i % 31) + 1), 32'(i * 7), 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("fill_level", {59'd0, level}, 64'd16);
    chk("fill_ovf", {63'd0, overflow}, 64'd1);
    chk("fill_drop", {48'd0, drop_cnt}, 64'd3);

    drive(1, 32'h2000, 5'd9, 32'hABCD, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("fp_level", {59'd0, level}, 64'd16);
    chk("fp_drop", {48'd0, drop_cnt}, 64'd3);
    chk("fp_head", {32'd0, trace_pc}, 64'h1004);

    trace_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      exp_pc = (i < 16) ? 32'h1000 + 32'(4 * i) : 32'h2000;
      chk("drain_pc", {32'd0, trace_pc}, {32'd0, exp_pc});
      step();
    end
    trace_ready = 1'b0;
    chk("drain_empty", {59'd0, level}, 64'd0);

    drops_before = mdrop;
    for (int i = 0; i < 40; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 5'd5, 32'(i),
            ($urandom_range(3) != 0));
      step();
    end
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step();
    trace_ready = 1'b0;
    chk("rand_empty", {59'd0, level}, 64'd0);
    chk("rand_nodrop", {48'd0, drop_cnt}, 64'(drops_before));

    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h4000 + 32'(4 * i), 5'd6, 32'h77, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_lvl", {59'd0, level}, 64'd5);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, trace_valid}, 64'd0);
    chk("arst_level", {59'd0, level}, 64'd0);
    chk("arst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("arst_ovf", {63'd0, overflow}, 64'd0);
    chk("arst_pc", {32'd0, trace_pc}, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    drive(1, 32'h5000, 5'd7, 32'h9, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("post_pc", {32'd0, trace_pc}, 64'h5000);
`ifdef RV_TRACE_SEQ_EN
    chk("post_seq", {48'd0, trace_seq}, 64'd0);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
